dist_filter_bcd: RTL

Downstream consumer of the SR04 ultrasonic controller's distance output. It takes each new 9-bit centimetre measurement on a one-cycle valid strobe, clamps it, and smooths it with a 4-sample moving average. The smoothed value is converted to 3 BCD digits for the FND display mux through a sequential double-dabble engine. It also drives a proximity flag with hysteresis for the alarm logic.

---
 rtl/dist_filter_bcd.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dist_filter_bcd.sv
// Clamps each distance sample, smooths it with a 4-sample moving average, and converts the result to 3 BCD digits.
// Latency: 11 clocks from the iValid sampling edge to the edge that asserts oDone.
// Backpressure: none; an iValid that arrives while busy is parked in a one-deep pending slot, and a newer one overwrites it.
module dist_filter_bcd #(
    parameter int MAX_CM  = 400,
    parameter int NEAR_CM = 10,
    parameter int HYST_CM = 2
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [8:0] iDistance,
    input  logic       iValid,
    input  logic       iClear,
    output logic       oBusy,
    output logic       oDone,
    output logic [8:0] oFiltered,
    output logic [3:0] oBcd_Hund,
    output logic [3:0] oBcd_Tens,
    output logic [3:0] oBcd_Ones,
    output logic       oNear
);

    localparam logic [8:0] MAX_V  = 9'(MAX_CM);
    localparam logic [8:0] NEAR_V = 9'(NEAR_CM);
    localparam logic [8:0] FAR_V  = 9'(NEAR_CM + HYST_CM);

    typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0][8:0] hist, hist_base;   // hist[0] is the newest sample
    logic [2:0]      cnt, cnt_base;
    logic            pend_vld;
    logic [8:0]      pend_dat;
    logic [8:0]      filt, bin_sr;
    logic [11:0]     bcd, bcd_adj;
    logic [3:0]      iter;
    logic [8:0]      sample, take, filt_nxt;
    logic [10:0]     sum;
    logic            pend_avail, start;

    // Clamp, capture selection, the clear-before-capture view of the history, averaging, and the BCD +3 correction
    always_comb begin
        sample     = (iDistance > MAX_V) ? MAX_V : iDistance;
        pend_avail = pend_vld && !iClear;
        start      = (state == IDLE) && (pend_avail || iValid);
        take       = pend_avail ? pend_dat : sample;
        hist_base  = iClear ? '0 : hist;
        cnt_base   = iClear ? 3'd0 : cnt;
        sum        = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
        filt_nxt   = (cnt == 3'd4) ? sum[10:2] : hist[0];
        bcd_adj    = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   state_nxt = CONVERT;
            CONVERT: if (iter == 4'd8) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= IDLE;
        else       state <= state_nxt;
    end

    // History, count and pending slot; a clear takes effect before a same-cycle capture
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            hist     <= '0;
            cnt      <= 3'd0;
            pend_vld <= 1'b0;
            pend_dat <= '0;
        end else begin
            if (start) begin
                hist <= {hist_base[2:0], take};
                cnt  <= (cnt_base == 3'd4) ? 3'd4 : cnt_base + 3'd1;
            end else begin
                hist <= hist_base;
                cnt  <= cnt_base;
            end
            if (state == IDLE) begin
                // The slot is drained by this start; a fresh iValid refills it only if the slot was the source
                pend_vld <= pend_avail && iValid;
                if (pend_avail && iValid) pend_dat <= sample;
            end else if (iValid) begin
                pend_vld <= 1'b1;
                pend_dat <= sample;
            end else if (iClear) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Filter result latch and sequential double-dabble (9 iterations, one bit per clock)
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            filt   <= '0;
            bin_sr <= '0;
            bcd    <= '0;
            iter   <= '0;
        end else if (state == ACCUM) begin
            filt   <= filt_nxt;
            bin_sr <= filt_nxt;
            bcd    <= '0;
            iter   <= '0;
        end else if (state == CONVERT) begin
            {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
            iter          <= iter + 4'd1;
        end
    end

    // Output registers, updated only when a conversion completes
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oDone     <= 1'b0;
            oFiltered <= '0;
            oBcd_Hund <= '0;
            oBcd_Tens <= '0;
            oBcd_Ones <= '0;
            oNear     <= 1'b0;
        end else begin
            oDone <= (state == DONE);
            if (state == DONE) begin
                oFiltered <= filt;
                oBcd_Hund <= bcd[11:8];
                oBcd_Tens <= bcd[7:4];
                oBcd_Ones <= bcd[3:0];
                if (filt < NEAR_V)       oNear <= 1'b1;
                else if (filt >= FAR_V)  oNear <= 1'b0;
            end
        end
    end

    assign oBusy = (state != IDLE);

endmodule
